// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampling edge/bit counters, frame FSM
// (start, data, optional parity, stop), LSB-first deserialiser and error flags.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Rx_IN,
  input  logic                  Sampled_bit,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  dat_samp_EN,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [PRESCALE_W-1:0] EDGE_ONE  = PRESCALE_W'(1);
  localparam logic [3:0]            LAST_DATA = 4'(DATA_WIDTH);

  state_t                  state, state_n;
  logic [PRESCALE_W-1:0]   prescale_r;
  logic                    par_en_r;
  logic                    par_typ_r;
  logic [3:0]              bit_cnt;
  logic [PRESCALE_W-1:0]   last_edge;
  logic                    bit_end;
  logic                    par_exp;

  // Prescale is 8/16/32, so the 6-bit subtraction never wraps.
  assign last_edge = prescale_r - EDGE_ONE;
  assign bit_end   = (state != IDLE) && (edge_cnt == last_edge);
  assign par_exp   = par_typ_r ? ~^P_DATA : ^P_DATA;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!Rx_IN) state_n = START;
      START:   if (bit_end) state_n = Sampled_bit ? IDLE : DATA;
      DATA:    if (bit_end && (bit_cnt == LAST_DATA)) state_n = par_en_r ? PARITY : STOP;
      PARITY:  if (bit_end) state_n = STOP;
      STOP:    if (bit_end) state_n = Rx_IN ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dat_samp_EN <= 1'b0;
    end else begin
      state       <= state_n;
      dat_samp_EN <= (state_n != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      prescale_r <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (state == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        // Frame configuration is frozen at the start edge.
        if (!Rx_IN) begin
          prescale_r <= Prescale;
          par_en_r   <= PAR_EN;
          par_typ_r  <= PAR_TYP;
        end
      end else if (bit_end) begin
        edge_cnt <= '0;
        bit_cnt  <= (state_n == START || state_n == IDLE) ? 4'd0 : bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + EDGE_ONE;
      end

      if (bit_end) begin
        unique case (state)
          START: begin
            if (!Sampled_bit) begin
              par_err <= 1'b0;
              stp_err <= 1'b0;
            end
          end
          DATA:   P_DATA  <= {Sampled_bit, P_DATA[DATA_WIDTH-1:1]};
          PARITY: par_err <= (Sampled_bit != par_exp);
          STOP: begin
            stp_err    <= ~Sampled_bit;
            data_valid <= Sampled_bit && !(par_en_r && par_err);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are driven bit-by-bit, good frames
// push an expected byte/cycle, a negedge monitor pops on every data_valid.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       Rx_IN;
  logic       Sampled_bit;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] edge_cnt;
  logic       dat_samp_EN;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .Rx_IN       (Rx_IN),
    .Sampled_bit (Sampled_bit),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .edge_cnt    (edge_cnt),
    .dat_samp_EN (dat_samp_EN),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cycle;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_dv;
  logic stp_at_t;
  logic stp_after_start;
  int   t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_edge_cnt"},    32'(edge_cnt),    32'd0);
    check({tag, "_dat_samp_EN"}, 32'(dat_samp_EN), 32'd0);
    check({tag, "_P_DATA"},      32'(P_DATA),      32'd0);
    check({tag, "_data_valid"},  32'(data_valid),  32'd0);
    check({tag, "_par_err"},     32'(par_err),     32'd0);
    check({tag, "_stp_err"},     32'(stp_err),     32'd0);
  endtask

  // Monitor: every data_valid must be a single-cycle pulse matching the queue head.
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      check("dv_one_cycle", 32'(prev_dv), 32'd0);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_dv: data_valid high with P_DATA=0x%0h, expected no pulse (cycle %0d)", P_DATA, cyc);
      end else begin
        check("p_data", 32'(P_DATA), 32'(sb_q[0].data));
        check("dv_cycle", cyc, sb_q[0].cycle);
        check("par_err_on_dv", 32'(par_err), 32'd0);
        check("stp_err_on_dv", 32'(stp_err), 32'd0);
        void'(sb_q.pop_front());
      end
    end
    prev_dv <= rst ? 1'b0 : data_valid;
  end

  // Drives one frame; Sampled_bit is aligned to the DUT's bit windows from cycle T.
  // Config inputs are scrambled once the frame has started to prove they are latched.
  task automatic send_frame(input logic [7:0] data, input logic [5:0] p,
                            input bit pe, input bit pt, input bit pbit, input bit sbit,
                            input bit from_idle, input bit chain, input bit expect_ok);
    logic bits [0:10];
    int   n;
    bit   en_ok;
    n = pe ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    bits[9]  = pbit;
    bits[10] = sbit;
    bits[n-1] = sbit;
    if (from_idle) begin
      Prescale    = p;
      PAR_EN      = pe;
      PAR_TYP     = pt;
      Rx_IN       = 1'b0;
      Sampled_bit = 1'b1;
      @(posedge clk); #1;
    end
    Prescale = p ^ 6'h15;
    PAR_EN   = ~pe;
    PAR_TYP  = ~pt;
    t0 = cyc;
    if (expect_ok) sb_q.push_back('{data: data, cycle: t0 + n * int'(p)});
    en_ok    = 1'b1;
    stp_at_t = stp_err;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < int'(p); j++) begin
        Rx_IN       = (i == n - 1 && j == int'(p) - 1) ? ~chain : bits[i];
        Sampled_bit = bits[i];
        if (!dat_samp_EN) en_ok = 1'b0;
        if (i == 1 && j == 0) stp_after_start = stp_err;
        @(posedge clk); #1;
      end
    end
    check("dat_samp_en_in_frame", 32'(en_ok), 32'd1);
    if (!chain) begin
      Rx_IN       = 1'b1;
      Sampled_bit = 1'b1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    Rx_IN       = 1'b1;
    Sampled_bit = 1'b1;
    Prescale    = 6'd8;
    PAR_EN      = 1'b0;
    PAR_TYP     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_edge_cnt", 32'(edge_cnt), 32'd0);

    // 1: Prescale 8, no parity, 0xA5 -> pulse at T+80
    send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t1_idle_dat_samp_EN", 32'(dat_samp_EN), 32'd0);
    check("t1_idle_edge_cnt",    32'(edge_cnt),    32'd0);
    check("t1_par_err",          32'(par_err),     32'd0);
    check("t1_stp_err",          32'(stp_err),     32'd0);

    // 2: Prescale 16, even parity, 0x3C: good parity then bad parity
    send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t2_good_par_err", 32'(par_err), 32'd0);
    send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_bad_par_err", 32'(par_err), 32'd1);
    check("t2_bad_P_DATA",  32'(P_DATA),  32'h3C);

    // 3: stop bit low on 0x55
    send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_stp_err", 32'(stp_err), 32'd1);
    check("t3_P_DATA",  32'(P_DATA),  32'h55);
    check("t3_par_err", 32'(par_err), 32'd0);

    // 4: 3-cycle start glitch; flags and data must survive
    Prescale    = 6'd8;
    PAR_EN      = 1'b0;
    Rx_IN       = 1'b0;
    Sampled_bit = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      Rx_IN = (k < 2) ? 1'b0 : 1'b1;
      if (k == 3) check("t4_edge_cnt_mid", 32'(edge_cnt), 32'd3);
      if (k == 7) check("t4_dat_samp_EN_last", 32'(dat_samp_EN), 32'd1);
      @(posedge clk); #1;
    end
    check("t4_edge_cnt",    32'(edge_cnt),    32'd0);
    check("t4_dat_samp_EN", 32'(dat_samp_EN), 32'd0);
    check("t4_P_DATA",      32'(P_DATA),      32'h55);
    check("t4_stp_err",     32'(stp_err),     32'd1);

    // 3 (cont.): next good frame clears stp_err at START->DATA
    send_frame(8'h96, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t3_stp_held_in_start",  32'(stp_at_t),        32'd1);
    check("t3_stp_cleared_in_data", 32'(stp_after_start), 32'd0);

    // 5: Prescale 32, odd parity, back-to-back 0x00 then 0xFF
    send_frame(8'h00, 6'd32, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'hFF, 6'd32, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // 6: async reset during the 4th data bit, then 0x81
    Prescale    = 6'd16;
    PAR_EN      = 1'b0;
    PAR_TYP     = 1'b0;
    Rx_IN       = 1'b0;
    Sampled_bit = 1'b1;
    @(posedge clk); #1;
    Sampled_bit = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    Sampled_bit = 1'b1;
    Rx_IN       = 1'b1;
    repeat (3 * 16 + 8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle_edge_cnt",    32'(edge_cnt),    32'd0);
    check("t6_idle_dat_samp_EN", 32'(dat_samp_EN), 32'd0);
    send_frame(8'h81, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
